// File: rtl/rhythm_pkg.sv
// rhythm_pkg: shared types and constants for the song sequencer.
// Holds the scheduler state encoding, default keycodes and chart word layout.
package rhythm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_WAIT,
        S_LAUNCH,
        S_DRAIN,
        S_DONE
    } sched_state_e;

    localparam logic [7:0]  KEY_START_DEF = 8'h2C;
    localparam logic [7:0]  KEY_QUIT_DEF  = 8'h01;

    // Chart word: [15:4] delay in frames, [3:0] lane mask.
    localparam int          CHART_W    = 16;
    localparam int          DELAY_W    = 12;
    localparam int          MASK_W     = 4;
    localparam logic [15:0] END_MARKER = 16'h0000;

    // Number of set bits in a lane vector (zero-extended to 16 bits by the caller).
    function automatic logic [7:0] popcount16(input logic [15:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/score_tracker.sv
// score_tracker: folds per-lane hit/miss pulses into score, combo and max combo.
// Only lanes currently in flight are considered; a hit on a lane masks a miss on it.
module score_tracker
    import rhythm_pkg::*;
#(
    parameter int NUM_LANES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic [NUM_LANES-1:0] hit_i,
    input  logic [NUM_LANES-1:0] miss_i,
    input  logic [NUM_LANES-1:0] active_i,
    output logic [NUM_LANES-1:0] clr_mask_o,
    output logic [15:0]          score_o,
    output logic [7:0]           combo_o,
    output logic [7:0]           max_combo_o
);

    logic [NUM_LANES-1:0] h;
    logic [NUM_LANES-1:0] m;
    logic [7:0]           n_hit;
    logic [15:0]          score_q, score_d;
    logic [7:0]           combo_q, combo_d;
    logic [7:0]           max_q, max_d;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [7:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {9'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    assign h          = hit_i & active_i;
    assign m          = miss_i & active_i & ~hit_i;
    assign clr_mask_o = h | m;
    assign n_hit      = popcount16(16'(h));

    // Next-state for score, combo and the running best combo.
    always_comb begin
        score_d = score_q;
        combo_d = combo_q;
        max_d   = max_q;
        if (clr_i) begin
            score_d = '0;
            combo_d = '0;
            max_d   = '0;
        end else if (en_i) begin
            score_d = sat_add16(score_q, n_hit);
            combo_d = (m != '0) ? 8'd0 : sat_add8(combo_q, n_hit);
            max_d   = (combo_d > max_q) ? combo_d : max_q;
        end
    end

    // Result registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            score_q <= '0;
            combo_q <= '0;
            max_q   <= '0;
        end else begin
            score_q <= score_d;
            combo_q <= combo_d;
            max_q   <= max_d;
        end
    end

    assign score_o     = score_q;
    assign combo_o     = combo_q;
    assign max_combo_o = max_q;

endmodule

// File: rtl/drop_scheduler.sv
// drop_scheduler: song-level sequencer for the arrow droppers.
// Walks the chart ROM, issues one-frame launch pulses, tracks lanes in flight
// and hands hit/miss reports to score_tracker for the HUD results.
module drop_scheduler
    import rhythm_pkg::*;
#(
    parameter int         NUM_LANES = 4,
    parameter int         CHART_AW  = 8,
    parameter logic [7:0] KEY_START = KEY_START_DEF,
    parameter logic [7:0] KEY_QUIT  = KEY_QUIT_DEF
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic [7:0]           keycode,
    input  logic [7:0]           keycode_second,
    output logic [CHART_AW-1:0]  chart_addr,
    input  logic [15:0]          chart_data,
    output logic [NUM_LANES-1:0] launch,
    input  logic [NUM_LANES-1:0] lane_hit,
    input  logic [NUM_LANES-1:0] lane_miss,
    output logic [NUM_LANES-1:0] lane_active,
    output logic [15:0]          score,
    output logic [7:0]           combo,
    output logic [7:0]           max_combo,
    output logic [7:0]           dropped,
    output logic                 playing,
    output logic                 finished
);

    localparam logic [CHART_AW-1:0] ADDR_ONE  = {{(CHART_AW-1){1'b0}}, 1'b1};
    localparam logic [CHART_AW-1:0] ADDR_LAST = '1;
    localparam logic [DELAY_W-1:0]  DLY_ONE   = {{(DELAY_W-1){1'b0}}, 1'b1};

    sched_state_e         state_q, state_d;
    logic [CHART_AW-1:0]  addr_q, addr_d;
    logic [DELAY_W-1:0]   delay_q, delay_d;
    logic [NUM_LANES-1:0] mask_q, mask_d;
    logic [NUM_LANES-1:0] active_q, active_d;
    logic [7:0]           dropped_q, dropped_d;
    logic [NUM_LANES-1:0] clr_mask;
    logic                 key_start, key_quit;
    logic                 in_play, start_go, quit_go;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    assign key_start = (keycode == KEY_START) || (keycode_second == KEY_START);
    assign key_quit  = (keycode == KEY_QUIT)  || (keycode_second == KEY_QUIT);
    assign in_play   = state_q inside {S_LOAD, S_FETCH, S_WAIT, S_LAUNCH, S_DRAIN};
    assign start_go  = (state_q == S_IDLE) && key_start;
    assign quit_go   = in_play && key_quit;

    score_tracker #(
        .NUM_LANES(NUM_LANES)
    ) u_trk (
        .clk_i      (frame_clk),
        .rst_i      (Reset),
        .en_i       (in_play),
        .clr_i      (start_go),
        .hit_i      (lane_hit),
        .miss_i     (lane_miss),
        .active_i   (active_q),
        .clr_mask_o (clr_mask),
        .score_o    (score),
        .combo_o    (combo),
        .max_combo_o(max_combo)
    );

    // Sequencer next-state, launch decode and lane bookkeeping.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        delay_d   = delay_q;
        mask_d    = mask_q;
        dropped_d = dropped_q;
        launch    = '0;
        active_d  = in_play ? (active_q & ~clr_mask) : active_q;

        case (state_q)
            S_IDLE: begin
                if (key_start) begin
                    active_d  = '0;
                    dropped_d = '0;
                    addr_d    = '0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: state_d = S_FETCH;
            S_FETCH: begin
                delay_d = chart_data[CHART_W-1:MASK_W];
                mask_d  = chart_data[NUM_LANES-1:0];
                if (chart_data == END_MARKER)
                    state_d = S_DRAIN;
                else if (chart_data[CHART_W-1:MASK_W] == '0)
                    state_d = S_LAUNCH;
                else
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                delay_d = delay_q - DLY_ONE;
                if (delay_q == DLY_ONE)
                    state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                // A lane clearing this same frame still counts as busy.
                launch    = mask_q & ~active_q;
                active_d  = active_d | launch;
                dropped_d = sat_add8(dropped_q, popcount16(16'(mask_q & active_q)));
                if (addr_q == ADDR_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = S_LOAD;
                end
            end
            S_DRAIN: begin
                if ((active_q & ~clr_mask) == '0)
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (key_quit)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything else in a playing frame.
        if (quit_go) begin
            state_d   = S_IDLE;
            active_d  = '0;
            launch    = '0;
            addr_d    = addr_q;
            dropped_d = dropped_q;
        end
    end

    // Control registers: state, chart address, lanes in flight, drop count.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            active_q  <= '0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            active_q  <= active_d;
            dropped_q <= dropped_d;
        end
    end

    // Chart word fields; only consumed after FETCH has loaded them.
    always_ff @(posedge frame_clk) begin
        delay_q <= delay_d;
        mask_q  <= mask_d;
    end

    assign chart_addr  = addr_q;
    assign lane_active = active_q;
    assign dropped     = dropped_q;
    assign playing     = in_play;
    assign finished    = (state_q == S_DONE);

endmodule
